// File: rtl/calc_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_queue_if
// Description : Command/operand bundle between the queue calculator ALU and
//               its operand queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                  op_valid;
    logic [1:0]            queue_op;
    logic [DATA_W-1:0]     result;
    logic                  calc_err;
    logic                  err_clr;
    logic [2*DATA_W-1:0]   operands;
    logic [DATA_W-1:0]     pop_data;
    logic                  pop_valid;
    logic [ADDR_W:0]       count;
    logic                  empty;
    logic                  full;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        output op_valid, queue_op, result, calc_err, err_clr,
        input  operands, pop_data, pop_valid, count, empty, full, err, err_code
    );

    modport slave (
        input  op_valid, queue_op, result, calc_err, err_clr,
        output operands, pop_data, pop_valid, count, empty, full, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/calc_queue.sv
`default_nettype none
// ============================================================================
// Module      : calc_queue
// Description : Circular operand FIFO executing ALU queue commands, with a
//               RUN/ERR error state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_queue #(
    parameter int         DATA_W         = 8,
    parameter int         DEPTH          = 16,
    parameter int         ADDR_W         = 4,
    parameter logic [1:0] Q_PUSH         = 2'b00,
    parameter logic [1:0] Q_SLEEP        = 2'b01,
    parameter logic [1:0] Q_POP          = 2'b11,
    parameter logic [1:0] Q_GET_AND_PUSH = 2'b10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    calc_queue_if.slave      q
);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_PTR_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W:0]   c_CNT_ZERO = '0;
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_CNT_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   c_CNT_FULL = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] c_ERR_NONE  = 2'b00;
    localparam logic [1:0] c_ERR_UNDER = 2'b01;
    localparam logic [1:0] c_ERR_OVER  = 2'b10;
    localparam logic [1:0] c_ERR_CALC  = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_err_code;
    logic [1:0]            w_err_code_nxt;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_head;
    logic [ADDR_W-1:0]     r_tail;
    logic [ADDR_W:0]       r_count;
    logic [DATA_W-1:0]     r_pop_data;
    logic                  r_pop_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_gap;
    logic                  w_empty;
    logic                  w_full;
    logic [ADDR_W-1:0]     w_head_p1;

    assign w_empty   = (r_count == c_CNT_ZERO);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_head_p1 = r_head + c_PTR_ONE;

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_gap          = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (q.op_valid) begin
                    if (q.calc_err) begin
                        w_state_nxt    = ST_ERR;
                        w_err_code_nxt = c_ERR_CALC;
                    end else begin
                        case (q.queue_op)
                            Q_PUSH: begin
                                if (w_full) begin
                                    w_state_nxt    = ST_ERR;
                                    w_err_code_nxt = c_ERR_OVER;
                                end else begin
                                    w_push = 1'b1;
                                end
                            end
                            Q_POP: begin
                                if (w_empty) begin
                                    w_state_nxt    = ST_ERR;
                                    w_err_code_nxt = c_ERR_UNDER;
                                end else begin
                                    w_pop = 1'b1;
                                end
                            end
                            Q_GET_AND_PUSH: begin
                                if (r_count < c_CNT_TWO) begin
                                    w_state_nxt    = ST_ERR;
                                    w_err_code_nxt = c_ERR_UNDER;
                                end else begin
                                    w_gap = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_ERR: begin
                if (q.err_clr) begin
                    w_state_nxt    = ST_RUN;
                    w_err_code_nxt = c_ERR_NONE;
                end
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_err_code_nxt = c_ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_err_code  <= c_ERR_NONE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err_code  <= w_err_code_nxt;
            r_pop_valid <= w_pop;
            if (w_pop) begin
                r_pop_data <= r_mem[r_head];
                r_head     <= w_head_p1;
                r_count    <= r_count - c_CNT_ONE;
            end else if (w_gap) begin
                r_head  <= r_head + c_PTR_TWO;
                r_tail  <= r_tail + c_PTR_ONE;
                r_count <= r_count - c_CNT_ONE;
            end else if (w_push) begin
                r_tail  <= r_tail + c_PTR_ONE;
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    // When full, tail equals head; get-and-push overwrites a slot consumed at the same edge.
    always_ff @(posedge clk) begin
        if (!rst && (w_push || w_gap)) begin
            r_mem[r_tail] <= q.result;
        end
    end

    assign q.operands[DATA_W-1:0]        = w_empty ? '0 : r_mem[r_head];
    assign q.operands[2*DATA_W-1:DATA_W] = (r_count < c_CNT_TWO) ? '0 : r_mem[w_head_p1];
    assign q.pop_data  = r_pop_data;
    assign q.pop_valid = r_pop_valid;
    assign q.count     = r_count;
    assign q.empty     = w_empty;
    assign q.full      = w_full;
    assign q.err       = (r_state == ST_ERR);
    assign q.err_code  = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_calc_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_queue
// Description : Directed self-checking bench for calc_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_queue;
    localparam logic [1:0] c_PUSH  = 2'b00;
    localparam logic [1:0] c_SLEEP = 2'b01;
    localparam logic [1:0] c_POP   = 2'b11;
    localparam logic [1:0] c_GAP   = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    calc_queue_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    calc_queue #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] res, input logic cerr);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.queue_op = op;
        bus.result   = res;
        bus.calc_err = cerr;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.calc_err = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        bus.op_valid = 1'b0;
        bus.queue_op = c_SLEEP;
        bus.result   = '0;
        bus.calc_err = 1'b0;
        bus.err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 16'(bus.count), 16'd0);
        chk("rst_empty", 16'(bus.empty), 16'd1);
        chk("rst_full", 16'(bus.full), 16'd0);
        chk("rst_err", 16'(bus.err), 16'd0);
        chk("rst_code", 16'(bus.err_code), 16'd0);
        chk("rst_operands", bus.operands, 16'h0000);
        chk("rst_pop_valid", 16'(bus.pop_valid), 16'd0);

        do_op(c_PUSH, 8'd5, 1'b0);
        chk("push1_operands", bus.operands, 16'h0005);
        do_op(c_PUSH, 8'd3, 1'b0);
        chk("push2_count", 16'(bus.count), 16'd2);
        chk("push2_operands", bus.operands, 16'h0305);
        chk("push2_empty", 16'(bus.empty), 16'd0);
        do_op(c_SLEEP, 8'hFF, 1'b0);
        chk("sleep_count", 16'(bus.count), 16'd2);

        do_op(c_GAP, 8'd8, 1'b0);
        chk("gap_count", 16'(bus.count), 16'd1);
        chk("gap_operands", bus.operands, 16'h0008);
        do_op(c_POP, 8'd0, 1'b0);
        chk("pop_valid", 16'(bus.pop_valid), 16'd1);
        chk("pop_data", 16'(bus.pop_data), 16'd8);
        chk("pop_count", 16'(bus.count), 16'd0);
        chk("pop_empty", 16'(bus.empty), 16'd1);
        @(posedge clk);
        #1;
        chk("pop_valid_pulse", 16'(bus.pop_valid), 16'd0);

        for (int i = 1; i <= 16; i++) do_op(c_PUSH, 8'(i), 1'b0);
        chk("fill_full", 16'(bus.full), 16'd1);
        chk("fill_count", 16'(bus.count), 16'd16);
        chk("fill_operands", bus.operands, 16'h0201);
        do_op(c_PUSH, 8'd17, 1'b0);
        chk("ovf_err", 16'(bus.err), 16'd1);
        chk("ovf_code", 16'(bus.err_code), 16'd2);
        chk("ovf_count", 16'(bus.count), 16'd16);
        do_op(c_POP, 8'd0, 1'b0);
        chk("err_pop_ignored", 16'(bus.count), 16'd16);
        chk("err_pop_no_valid", 16'(bus.pop_valid), 16'd0);
        do_clr();
        chk("clr_err", 16'(bus.err), 16'd0);
        chk("clr_code", 16'(bus.err_code), 16'd0);
        chk("clr_count", 16'(bus.count), 16'd16);

        do_op(c_GAP, 8'hAA, 1'b0);
        chk("gapfull_count", 16'(bus.count), 16'd15);
        chk("gapfull_operands", bus.operands, 16'h0403);
        chk("gapfull_err", 16'(bus.err), 16'd0);
        for (int i = 3; i <= 16; i++) begin
            do_op(c_POP, 8'd0, 1'b0);
            chk("drain_data", 16'(bus.pop_data), 16'(i));
        end
        chk("drain_operands", bus.operands, 16'h00AA);
        do_op(c_POP, 8'd0, 1'b0);
        chk("drain_last", 16'(bus.pop_data), 16'h00AA);
        chk("drain_empty", 16'(bus.empty), 16'd1);

        for (int i = 0; i < 20; i++) begin
            v = 8'(i * 7 + 1);
            do_op(c_PUSH, v, 1'b0);
            chk("wrap_head", bus.operands, {8'h00, v});
            do_op(c_POP, 8'd0, 1'b0);
            chk("wrap_data", 16'(bus.pop_data), 16'(v));
        end
        chk("wrap_count", 16'(bus.count), 16'd0);

        do_op(c_POP, 8'd0, 1'b0);
        chk("udf_pop_code", 16'(bus.err_code), 16'd1);
        chk("udf_pop_err", 16'(bus.err), 16'd1);
        do_clr();
        do_op(c_PUSH, 8'h55, 1'b0);
        do_op(c_GAP, 8'h77, 1'b0);
        chk("udf_gap_code", 16'(bus.err_code), 16'd1);
        chk("udf_gap_count", 16'(bus.count), 16'd1);
        chk("udf_gap_operands", bus.operands, 16'h0055);
        do_clr();
        do_op(c_PUSH, 8'h66, 1'b1);
        chk("calc_code", 16'(bus.err_code), 16'd3);
        chk("calc_count", 16'(bus.count), 16'd1);
        do_op(c_PUSH, 8'd7, 1'b0);
        chk("err_push_ignored", 16'(bus.count), 16'd1);
        chk("err_push_operands", bus.operands, 16'h0055);

        @(negedge clk);
        rst          = 1'b1;
        bus.op_valid = 1'b1;
        bus.queue_op = c_PUSH;
        bus.result   = 8'h99;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        chk("midrst_count", 16'(bus.count), 16'd0);
        chk("midrst_err", 16'(bus.err), 16'd0);
        chk("midrst_code", 16'(bus.err_code), 16'd0);
        chk("midrst_operands", bus.operands, 16'h0000);
        do_op(c_PUSH, 8'h42, 1'b0);
        chk("run_after_rst", bus.operands, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
